alu_issue: RTL
==============

ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 32, datapath width.
REQ-002 SHALL have parameter ALU_LAT, default 1, range 1-7, number of clkout cycles from operand drive to result sampling.
REQ-003 clkout  in  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 instr_valid  in  1  instruction offered.
REQ-006 instr_ready  out  1  instruction accepted when instr_valid and instr_ready are both high at a rising edge.
REQ-007 instr_opcode  in  8  ALU opcode.
REQ-008 instr_rd, instr_rs  in  3 each  destination/A-source register and B-source register.
REQ-009 instr_imm  in  DATA_SIZE  direct value; instr_fl  in  1  carry-mask request.
REQ-010 ld_en, ld_addr[2:0], ld_data[DATA_SIZE]  in  external register-file load port.
REQ-011 alu_opcode[8], alu_a[DATA_SIZE], alu_b[DATA_SIZE], alu_val[DATA_SIZE], alu_cin, alu_fl  out  registered operands to the ALU.
REQ-012 alu_result[DATA_SIZE], alu_flags[5]  in  ALU outputs; flags ordered [Z C S P V].
REQ-013 status[5]  out  status register [Z C S P V]; retire  out  1  one-cycle pulse per completed instruction.

Function
REQ-014 SHALL hold an 8-entry x DATA_SIZE register file r0-r7, all writable.
REQ-015 FSM states SHALL be IDLE, EXEC, WB.
REQ-016 IDLE: instr_ready high; on accept, alu_opcode<=instr_opcode, alu_a<=r[instr_rd], alu_b<=r[instr_rs], alu_val<=instr_imm, alu_cin<=status[3] (C), alu_fl<=instr_fl, latch rd; next state EXEC.
REQ-017 EXEC SHALL last exactly ALU_LAT cycles (down-counter), alu_* outputs held constant throughout.
REQ-018 WB SHALL last one cycle with retire high; on the edge ending WB: r[rd]<=alu_result, status<=alu_flags.
REQ-019 From WB SHALL go to IDLE unless a skid entry is pending (REQ-028).
REQ-020 ld_en writes ld_data to r[ld_addr] on any edge; if WB writes the same address on the same edge, WB data wins.
REQ-021 Operand reads SHALL see all writes committed on earlier edges; an ld write on the accept edge is not visible to that instruction.
REQ-022 Latency accept-to-retire SHALL be ALU_LAT+1 cycles; throughput without skid one instruction per ALU_LAT+2 cycles.
REQ-023 instr_* SHALL be ignored when instr_ready is low.
REQ-024 Arithmetic SHALL be none inside the block; alu_result stored unmodified, DATA_SIZE bits.

Reset
REQ-025 On rst_n low, immediately: state IDLE, counter 0, all r0-r7 = 0, status = 0, all alu_* = 0, retire = 0, skid empty.
REQ-026 Reset during EXEC or WB SHALL abandon the instruction with no register or status write; instr_ready high on first edge after rst_n rises.

Configuration
REQ-027 Macro ALU_ISSUE_SKID_EN SHALL select a one-entry skid buffer.
REQ-028 Defined: instr_ready = not skid_full in every state; an instruction accepted in EXEC/WB is held; from WB with skid pending, next state EXEC with operands loaded on the WB edge, forwarding alu_result for any source equal to the retiring rd and alu_flags[3] for alu_cin; skid clears on that edge; throughput one per ALU_LAT+1 cycles.
REQ-029 Not defined: no skid storage; instr_ready high only in IDLE.

Verification
REQ-030 Reset: assert rst_n=0 mid-EXEC -> instr_ready=1, status=00000, retire=0, r[rd] unchanged (0).
REQ-031 ld r1=-2, r2=2; issue opcode ADA rd=1 rs=2; ALU returns 0, flags 10000 -> alu_a=-2, alu_b=2, retire at accept+ALU_LAT+1, r1=0, status=10000.
REQ-032 status C=1 then issue any opcode with fl=1 -> alu_cin=1, alu_fl=1 for all EXEC cycles.
REQ-033 ALU_LAT=3: accept at cycle 0 -> EXEC cycles 1-3, retire cycle 4, instr_ready low cycles 1-4 (skid undefined).
REQ-034 ALU_ISSUE_SKID_EN: ADA r1,r2 then back-to-back ADA r3,r1 with first result 7 -> second issue alu_b=7 (forwarded), second retire ALU_LAT+1 cycles after first.
REQ-035 ld_en to r4 on same edge as WB to r4 -> r4 holds alu_result.

Source files
------------

// File: rtl/alu_issue_if.sv
// Instruction, register-load and ALU operand/result bundle for alu_issue.
// The master side is the instruction source, the register loader and the ALU.
interface alu_issue_if #(
    parameter int unsigned DATA_SIZE = 32
) ();
    logic                 instr_valid;
    logic                 instr_ready;
    logic [7:0]           instr_opcode;
    logic [2:0]           instr_rd;
    logic [2:0]           instr_rs;
    logic [DATA_SIZE-1:0] instr_imm;
    logic                 instr_fl;

    logic                 ld_en;
    logic [2:0]           ld_addr;
    logic [DATA_SIZE-1:0] ld_data;

    logic [7:0]           alu_opcode;
    logic [DATA_SIZE-1:0] alu_a;
    logic [DATA_SIZE-1:0] alu_b;
    logic [DATA_SIZE-1:0] alu_val;
    logic                 alu_cin;
    logic                 alu_fl;
    logic [DATA_SIZE-1:0] alu_result;
    logic [4:0]           alu_flags;

    logic [4:0]           status;
    logic                 retire;

    modport master (
        output instr_valid, instr_opcode, instr_rd, instr_rs, instr_imm, instr_fl,
        output ld_en, ld_addr, ld_data, alu_result, alu_flags,
        input  instr_ready, alu_opcode, alu_a, alu_b, alu_val, alu_cin, alu_fl,
        input  status, retire
    );

    modport slave (
        input  instr_valid, instr_opcode, instr_rd, instr_rs, instr_imm, instr_fl,
        input  ld_en, ld_addr, ld_data, alu_result, alu_flags,
        output instr_ready, alu_opcode, alu_a, alu_b, alu_val, alu_cin, alu_fl,
        output status, retire
    );
endinterface

// File: rtl/alu_issue.sv
// Single-issue front end for an external ALU: 8-entry register file, status flags, IDLE/EXEC/WB.
// Define ALU_ISSUE_SKID_EN to add a one-entry skid buffer for back-to-back issue.
module alu_issue #(
    parameter int unsigned DATA_SIZE = 32,
    parameter int unsigned ALU_LAT   = 1
) (
    input  logic       clkout,
    input  logic       rst_n,
    alu_issue_if.slave bus
);
    localparam int unsigned CNT_W = 3;
    localparam int unsigned RF_N  = 8;
    localparam int unsigned C_BIT = 3;

    typedef enum logic [1:0] {IDLE, EXEC, WB} state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2:0]           rd_q, rd_d;
    logic [DATA_SIZE-1:0] rf_q [RF_N];
    logic [DATA_SIZE-1:0] rf_d [RF_N];
    logic [4:0]           status_q, status_d;
    logic                 retire_q, retire_d;
    logic                 ready_q, ready_d;
    logic [7:0]           op_q, op_d;
    logic [DATA_SIZE-1:0] a_q, a_d, b_q, b_d, val_q, val_d;
    logic                 cin_q, cin_d, fl_q, fl_d;

    logic                 accept;
    logic                 src_valid;
    logic [7:0]           src_op;
    logic [2:0]           src_rd, src_rs;
    logic [DATA_SIZE-1:0] src_imm;
    logic                 src_fl;
    logic                 in_wb;

`ifdef ALU_ISSUE_SKID_EN
    logic                 skid_full_q, skid_full_d;
    logic [7:0]           skid_op_q, skid_op_d;
    logic [2:0]           skid_rd_q, skid_rd_d, skid_rs_q, skid_rs_d;
    logic [DATA_SIZE-1:0] skid_imm_q, skid_imm_d;
    logic                 skid_fl_q, skid_fl_d;
`endif

    assign accept = bus.instr_valid && ready_q;
    assign in_wb  = (state_q == WB);

    // Pick the next instruction to issue: a held skid entry has priority over the port
    always_comb begin
        src_valid = accept;
        src_op    = bus.instr_opcode;
        src_rd    = bus.instr_rd;
        src_rs    = bus.instr_rs;
        src_imm   = bus.instr_imm;
        src_fl    = bus.instr_fl;
`ifdef ALU_ISSUE_SKID_EN
        skid_full_d = skid_full_q;
        skid_op_d   = skid_op_q;
        skid_rd_d   = skid_rd_q;
        skid_rs_d   = skid_rs_q;
        skid_imm_d  = skid_imm_q;
        skid_fl_d   = skid_fl_q;
        if (skid_full_q) begin
            src_valid = 1'b1;
            src_op    = skid_op_q;
            src_rd    = skid_rd_q;
            src_rs    = skid_rs_q;
            src_imm   = skid_imm_q;
            src_fl    = skid_fl_q;
            if (in_wb) skid_full_d = 1'b0;
        end else if (accept && state_q == EXEC) begin
            skid_full_d = 1'b1;
            skid_op_d   = bus.instr_opcode;
            skid_rd_d   = bus.instr_rd;
            skid_rs_d   = bus.instr_rs;
            skid_imm_d  = bus.instr_imm;
            skid_fl_d   = bus.instr_fl;
        end
`endif
    end

    // Next-state, register-file and operand logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rd_d     = rd_q;
        rf_d     = rf_q;
        status_d = status_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        val_d    = val_q;
        cin_d    = cin_q;
        fl_d     = fl_q;

        if (bus.ld_en) rf_d[bus.ld_addr] = bus.ld_data;

        case (state_q)
            IDLE: ;
            EXEC: begin
                if (cnt_q == '0) state_d = WB;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            WB: begin
                rf_d[rd_q] = bus.alu_result;
                status_d   = bus.alu_flags;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Issue from IDLE or straight out of WB; the retiring result bypasses the file
        if (src_valid && (state_q == IDLE || in_wb)) begin
            state_d = EXEC;
            cnt_d   = CNT_W'(ALU_LAT - 1);
            rd_d    = src_rd;
            op_d    = src_op;
            val_d   = src_imm;
            fl_d    = src_fl;
            a_d     = (in_wb && src_rd == rd_q) ? bus.alu_result : rf_q[src_rd];
            b_d     = (in_wb && src_rs == rd_q) ? bus.alu_result : rf_q[src_rs];
            cin_d   = in_wb ? bus.alu_flags[C_BIT] : status_q[C_BIT];
        end

        retire_d = (state_d == WB);
`ifdef ALU_ISSUE_SKID_EN
        ready_d  = !skid_full_d;
`else
        ready_d  = (state_d == IDLE);
`endif
    end

    always_ff @(posedge clkout or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rd_q     <= '0;
            status_q <= '0;
            retire_q <= 1'b0;
            ready_q  <= 1'b1;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            val_q    <= '0;
            cin_q    <= 1'b0;
            fl_q     <= 1'b0;
            for (int i = 0; i < RF_N; i++) rf_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rd_q     <= rd_d;
            status_q <= status_d;
            retire_q <= retire_d;
            ready_q  <= ready_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            val_q    <= val_d;
            cin_q    <= cin_d;
            fl_q     <= fl_d;
            for (int i = 0; i < RF_N; i++) rf_q[i] <= rf_d[i];
        end
    end

`ifdef ALU_ISSUE_SKID_EN
    always_ff @(posedge clkout or negedge rst_n) begin
        if (!rst_n) begin
            skid_full_q <= 1'b0;
            skid_op_q   <= '0;
            skid_rd_q   <= '0;
            skid_rs_q   <= '0;
            skid_imm_q  <= '0;
            skid_fl_q   <= 1'b0;
        end else begin
            skid_full_q <= skid_full_d;
            skid_op_q   <= skid_op_d;
            skid_rd_q   <= skid_rd_d;
            skid_rs_q   <= skid_rs_d;
            skid_imm_q  <= skid_imm_d;
            skid_fl_q   <= skid_fl_d;
        end
    end
`endif

    assign bus.instr_ready = ready_q;
    assign bus.alu_opcode  = op_q;
    assign bus.alu_a       = a_q;
    assign bus.alu_b       = b_q;
    assign bus.alu_val     = val_q;
    assign bus.alu_cin     = cin_q;
    assign bus.alu_fl      = fl_q;
    assign bus.status      = status_q;
    assign bus.retire      = retire_q;
endmodule
